base_skid_reg: RTL and testbench

//  Registered valid/ready pipeline slice: a 2-entry skid buffer with a forward data/valid path and a reverse ready path.

---
 rtl/base_skid_pkg.sv | 24 ++
 rtl/base_skid_slot.sv | 26 ++
 rtl/base_skid_reg.sv | 151 +++++++++++++++
 tb/tb_base_skid_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/base_skid_pkg.sv
`default_nettype none
// ============================================================================
// base_skid_pkg : state encoding and slot sizing for the base_skid_reg slice
// Optional feature macro: BASE_SKID_PARITY_EN (adds a parity bit per slot)
// Revision: 1.0
// ============================================================================
package base_skid_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_HALF  = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

    function automatic int slot_width(input int data_width);
`ifdef BASE_SKID_PARITY_EN
        return data_width + 1;
`else
        return data_width;
`endif
    endfunction

endpackage : base_skid_pkg
`default_nettype wire

// File: rtl/base_skid_slot.sv
`default_nettype none
// ============================================================================
// base_skid_slot : load-enabled storage register with async reset to rstv
// Revision: 1.0
// ============================================================================
module base_skid_slot #(
    parameter int               width = 1,
    parameter logic [width-1:0] rstv  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= rstv;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : base_skid_slot
`default_nettype wire

// File: rtl/base_skid_reg.sv
`default_nettype none
// ============================================================================
// base_skid_reg : 2-entry registered valid/ready skid slice, all outputs flopped
// Optional feature macro: BASE_SKID_PARITY_EN (parity storage + sticky check)
// Revision: 1.0
// ============================================================================
module base_skid_reg
    import base_skid_pkg::*;
#(
    parameter int               width = 1,
    parameter logic [width-1:0] rstv  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    input  logic [width-1:0] i_d,
    input  logic             i_par,
    output logic             i_r,
    output logic             o_v,
    output logic [width-1:0] o_d,
    output logic             o_par,
    input  logic             o_r,
    output logic             o_perr
);

    localparam int SW = slot_width(width);

`ifdef BASE_SKID_PARITY_EN
    localparam logic [SW-1:0] SLOT_RST = {^rstv, rstv};
`else
    localparam logic [SW-1:0] SLOT_RST = rstv;
`endif

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] next_state;
    logic            accept;
    logic            take;
    logic            main_load;
    logic            skid_load;
    logic            ir_next;
    logic            ov_next;
    logic [SW-1:0]   in_slot;
    logic [SW-1:0]   main_d;
    logic [SW-1:0]   main_q;
    logic [SW-1:0]   skid_q;

    assign accept = i_v & i_r;
    assign take   = o_v & o_r;

`ifdef BASE_SKID_PARITY_EN
    assign in_slot = {i_par, i_d};
`else
    logic unused_par;
    assign unused_par = i_par;
    assign in_slot    = i_d;
`endif

    // State register together with the flopped handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
            o_v   <= 1'b0;
            i_r   <= 1'b0;
        end else begin
            state <= next_state;
            o_v   <= ov_next;
            i_r   <= ir_next;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_HALF;
            ST_HALF: begin
                if (accept && !take)      next_state = ST_FULL;
                else if (!accept && take) next_state = ST_EMPTY;
            end
            ST_FULL:  if (take) next_state = ST_HALF;
            default:  next_state = ST_EMPTY;
        endcase
    end

    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_slot;
        case (state)
            ST_EMPTY: main_load = accept;
            ST_HALF: begin
                main_load = accept & take;
                skid_load = accept & ~take;
            end
            ST_FULL: begin
                main_load = take;
                main_d    = skid_q;
            end
            default: ;
        endcase
        ir_next = (next_state != ST_FULL);
        ov_next = (next_state != ST_EMPTY);
    end

    base_skid_slot #(
        .width (SW),
        .rstv  (SLOT_RST)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    base_skid_slot #(
        .width (SW),
        .rstv  (SLOT_RST)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_slot),
        .q     (skid_q)
    );

    assign o_d = main_q[width-1:0];

`ifdef BASE_SKID_PARITY_EN
    logic perr_q;
    logic perr_now;

    assign o_par    = main_q[width];
    assign perr_now = o_v & (^{o_d, o_par});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (perr_now) begin
            perr_q <= 1'b1;
        end
    end

    // Flag is visible in the same cycle the bad beat is presented
    assign o_perr = perr_q | perr_now;
`else
    assign o_par  = ^o_d;
    assign o_perr = 1'b0;
`endif

endmodule : base_skid_reg
`default_nettype wire

// File: tb/tb_base_skid_reg.sv
`default_nettype none
// Testbench for base_skid_reg: vector table, corner sequences and a scoreboard.
module tb_base_skid_reg;

    localparam int             W    = 8;
    localparam logic [W-1:0]   RSTV = 8'h5A;
`ifdef BASE_SKID_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         i_v   = 1'b0;
    logic [W-1:0] i_d   = '0;
    logic         i_par = 1'b0;
    logic         o_r   = 1'b0;
    logic         i_r;
    logic         o_v;
    logic [W-1:0] o_d;
    logic         o_par;
    logic         o_perr;

    base_skid_reg #(
        .width (W),
        .rstv  (RSTV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_v    (i_v),
        .i_d    (i_d),
        .i_par  (i_par),
        .i_r    (i_r),
        .o_v    (o_v),
        .o_d    (o_d),
        .o_par  (o_par),
        .o_r    (o_r),
        .o_perr (o_perr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop on take; also checks AXI-style hold
    logic [W-1:0] sb_q[$];
    logic         held   = 1'b0;
    logic [W-1:0] held_d = '0;

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", o_v, 1);
                check("hold_data", o_d, held_d);
            end
            if (o_v && o_r) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got beat %0h expected none", o_d);
                end else begin
                    check("sb_data", o_d, sb_q.pop_front());
                end
            end
            if (i_v && i_r) sb_q.push_back(i_d);
            held   = o_v && !o_r;
            held_d = o_d;
        end
    end

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        logic [W-1:0] ed;
        logic         er;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [W-1:0] d, input logic r,
                           input logic ev, input logic [W-1:0] ed, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed; t.er = er;
        vecs.push_back(t);
    endtask

    task automatic apply(input logic v, input logic [W-1:0] d, input logic r);
        i_v   = v;
        i_d   = d;
        i_par = ^d;
        o_r   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming 0x01..0x10 at full rate
        for (int k = 1; k <= 16; k++) add_vec(1'b1, W'(k), 1'b1, 1'b1, W'(k), 1'b1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1);
        // Backpressure with three beats, then release
        add_vec(1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1);
        add_vec(1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0);
        add_vec(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0);
        add_vec(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1);
        add_vec(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1'b1);
        // Drain FULL -> HALF -> EMPTY
        add_vec(1'b1, 8'hB1, 1'b0, 1'b1, 8'hB1, 1'b1);
        add_vec(1'b1, 8'hB2, 1'b0, 1'b1, 8'hB1, 1'b0);
        add_vec(1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 8'hB2, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_o_v", o_v, 0);
        check("rst_i_r", i_r, 0);
        check("rst_o_d", o_d, RSTV);
        check("rst_o_perr", o_perr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_i_r", i_r, 1);
        check("first_edge_o_v", o_v, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n].v, vecs[n].d, vecs[n].r);
            check($sformatf("vec%0d_o_v", n), o_v, vecs[n].ev);
            check($sformatf("vec%0d_o_d", n), o_d, vecs[n].ed);
            check($sformatf("vec%0d_i_r", n), i_r, vecs[n].er);
            check($sformatf("vec%0d_o_par", n), o_par, ^vecs[n].ed);
            check($sformatf("vec%0d_o_perr", n), o_perr, 0);
        end

        // Reset while FULL
        apply(1'b1, 8'hC1, 1'b0);
        apply(1'b1, 8'hC2, 1'b0);
        check("full_i_r", i_r, 0);
        check("full_o_d", o_d, 8'hC1);
        reset = 1'b1;
        #1;
        check("async_rst_o_v", o_v, 0);
        check("async_rst_i_r", i_r, 0);
        check("async_rst_o_perr", o_perr, 0);
        check("async_rst_o_d", o_d, RSTV);
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_v   = 1'b0;
        o_r   = 1'b1;
        check("rel_i_r_before_edge", i_r, 0);
        @(posedge clk);
        #1;
        check("rel_i_r", i_r, 1);
        check("rel_no_replay", o_v, 0);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            apply(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            if (o_v === 1'b0) check("rand_ir_when_not_full", i_r, 1);
        end
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, 8'h00, 1'b1);
        check("rand_sb_empty", sb_q.size(), 0);
        check("rand_drained_o_v", o_v, 0);

        // Bad parity beat 0x03 with i_par=1
        i_v = 1'b1; i_d = 8'h03; i_par = 1'b1; o_r = 1'b0;
        @(posedge clk);
        #1;
        i_v = 1'b0;
        check("par_o_d", o_d, 8'h03);
        check("par_o_par", o_par, PAR_EN ? 1 : 0);
        check("par_perr_first", o_perr, PAR_EN ? 1 : 0);
        @(posedge clk);
        #1;
        check("par_perr_held", o_perr, PAR_EN ? 1 : 0);
        o_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("par_drained_o_v", o_v, 0);
        check("par_perr_sticky", o_perr, PAR_EN ? 1 : 0);
        reset = 1'b1;
        #1;
        check("par_perr_cleared", o_perr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_base_skid_reg
`default_nettype wire
